mux_share_arbiter: RTL
======================

Name: mux_share_arbiter

Overview:
- Round-robin arbiter that shares the 4-bit 2:1 switch mux output (LEDR[3:0]) between two requesters: X on SW[3:0] and Y on SW[7:4].
- Each requester raises a request switch. The arbiter grants one requester at a time, enforces a time quantum, and rotates fairly under contention.
- A pushbutton forces the current grant to release.
- Top-level board block: switches/keys in, LEDs out.

Parameters:
- WIDTH, 4, data width per requester; must be ≤4 (fixed pin map).
- QUANTUM, 50_000_000, clock cycles per grant slice before a contended handover (1 s at 50 MHz); benches override to 4.

Ports:
- CLOCK_50  input  1  system clock, all logic on rising edge.
- KEY  input  4  active-low pushbuttons.
  - KEY[0]: asynchronous active-low reset.
  - KEY[1]: force-release.
  - KEY[3:2]: unused.
- SW  input  10  SW[3:0] = X data, SW[7:4] = Y data, SW[8] = X request, SW[9] = Y request.
- LEDR  output  10  LEDR[3:0] = granted data, LEDR[7:4] = 0, LEDR[8] = X granted, LEDR[9] = Y granted.

Behaviour:
- Reset (KEY[0]=0, asynchronous, active-low):
  - state=IDLE, last_grant=Y, counter=0, all synchronizer/data registers=0.
  - LEDR=0 immediately, with no clock needed.
  - Reset mid-grant aborts the grant at once.
  - On release, the first grant under contention goes to X.
- Input conditioning:
  - SW[9:8] and KEY[1] each pass through a 2-flop synchronizer (synchronizer reset value for KEY[1] = 1).
  - rel_pulse = one-cycle pulse on a synced KEY[1] falling edge.
  - data_q <= SW[7:0] every cycle (1-cycle data latency).
- States: IDLE, GRANT_X, GRANT_Y.
- IDLE transitions:
  - rx&ry: grant the requester ≠ last_grant.
  - rx only: GRANT_X.
  - ry only: GRANT_Y.
  - neither: stay.
- On every grant entry, counter <= QUANTUM-1.
- GRANT_X (GRANT_Y symmetric), priority order:
  1. !rx or rel_pulse: last_grant<=X; go GRANT_Y if ry (counter reloaded), else IDLE.
  2. counter==0 and ry: last_grant<=X; go GRANT_Y, reload.
  3. counter==0 and !ry: stay, reload (uncontended holder keeps the slice indefinitely).
  4. else: counter decrements.
- Release coinciding with expiry behaves identically to release.
- If release leaves the requester's own switch high and no other request is pending: IDLE for 1 cycle, then re-granted to the same requester.
- Outputs are combinational from registered state/data_q only (no input-to-output paths):
  - LEDR[3:0] = data_q[3:0] in GRANT_X, data_q[7:4] in GRANT_Y, 0 in IDLE.
  - LEDR[8] = (state==GRANT_X), LEDR[9] = (state==GRANT_Y); never both high.
  - LEDR[7:4] = 0 always.
- Latency:
  - A request switch set before edge n gives grant LEDs high after edge n+2 (3rd rising edge).
  - Request drop gives release on the same 3-edge latency.
  - Handover X→Y is a direct transition: no IDLE cycle, no gap or overlap on LEDR[9:8].
- Counter width = $clog2(QUANTUM).
- QUANTUM=1 means a handover decision is made every cycle under contention.

Test Plan:
- Reset, then SW=0x105 (X req, X=5, Y=0) → 3rd edge: LEDR[8]=1, LEDR[3:0]=5, LEDR[9]=0; change SW[3:0] to 0xA → LEDR[3:0]=0xA one cycle later.
- QUANTUM=4; SW=0x3A5 (both request, X=5, Y=0xA) → grant X first with LEDR=0x105 for 4 cycles, then LEDR=0x20A for 4 cycles, alternating; never LEDR[9:8]=11 or a 00 gap.
- In GRANT_X with both requesting, clear SW[8] → 3 edges later LEDR[9]=1 directly; clear SW[9] as well → IDLE, LEDR=0.
- GRANT_X only (SW[8]=1), pulse KEY[1] low 3 cycles → exactly one IDLE cycle (LEDR=0), then GRANT_X again; with SW[9]=1 also set → GRANT_Y, no IDLE.
- Assert KEY[0]=0 mid GRANT_Y between clock edges → LEDR=0 before the next edge; release reset with both requests held → first grant is X.
- Only Y requesting with QUANTUM=4 for 20 cycles → GRANT_Y held continuously, counter reloads, no spurious transition.

Source files
------------

// File: rtl/mux_share_arbiter.sv
// Purpose: round-robin share of one 4-bit LED output between two switch requesters (X on SW[3:0], Y on SW[7:4]).
// Latency: request/release switch to grant LEDs on the 3rd rising edge; data switch to LEDs in 1 cycle.
// Backpressure: none; a loser waits for a drop, a KEY[1] release or expiry of the holder's time quantum.
module mux_share_arbiter #(
    parameter int WIDTH   = 4,
    parameter int QUANTUM = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR
);

    // A counter of at least one bit keeps QUANTUM=1 legal (reload value 0 -> decide every cycle).
    localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(QUANTUM - 1);
    // Only the low WIDTH bits of each requester's nibble reach the LEDs.
    localparam logic [3:0] DMASK = 4'((1 << WIDTH) - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_X = 2'd1;
    localparam logic [1:0] GRANT_Y = 2'd2;

    localparam logic LG_X = 1'b0;
    localparam logic LG_Y = 1'b1;

    logic          rst_n;
    logic [1:0]    req_s1, req_s2;
    logic          rel_s1, rel_s2, rel_d;
    logic          rel_pulse;
    logic          rx, ry;
    logic [7:0]    data_q;
    logic [1:0]    state, state_nxt;
    logic          last_grant, last_nxt;
    logic [CW-1:0] counter, cnt_nxt;
    logic          unused_keys;

    assign rst_n       = KEY[0];
    assign unused_keys = ^KEY[3:2];

    // Two-flop synchronizers for the request switches and the release button, plus data capture.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            req_s1 <= 2'b00;
            req_s2 <= 2'b00;
            rel_s1 <= 1'b1;
            rel_s2 <= 1'b1;
            rel_d  <= 1'b1;
            data_q <= 8'h00;
        end else begin
            req_s1 <= SW[9:8];
            req_s2 <= req_s1;
            rel_s1 <= KEY[1];
            rel_s2 <= rel_s1;
            rel_d  <= rel_s2;
            data_q <= SW[7:0];
        end
    end

    assign rx        = req_s2[0];
    assign ry        = req_s2[1];
    // Button is active-low: a synced 1->0 transition is one release request.
    assign rel_pulse = rel_d & ~rel_s2;

    // Grant decision: drop/release first, then quantum expiry, otherwise count down the slice.
    always_comb begin
        state_nxt = state;
        last_nxt  = last_grant;
        cnt_nxt   = counter;
        case (state)
            IDLE: begin
                if (rx && ry) begin
                    cnt_nxt = RELOAD;
                    state_nxt = (last_grant == LG_Y) ? GRANT_X : GRANT_Y;
                end else if (rx) begin
                    cnt_nxt   = RELOAD;
                    state_nxt = GRANT_X;
                end else if (ry) begin
                    cnt_nxt   = RELOAD;
                    state_nxt = GRANT_Y;
                end
            end
            GRANT_X: begin
                if (!rx || rel_pulse) begin
                    last_nxt = LG_X;
                    if (ry) begin
                        state_nxt = GRANT_Y;
                        cnt_nxt   = RELOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (counter == '0) begin
                    cnt_nxt = RELOAD;
                    if (ry) begin
                        last_nxt  = LG_X;
                        state_nxt = GRANT_Y;
                    end
                end else begin
                    cnt_nxt = counter - CW'(1);
                end
            end
            GRANT_Y: begin
                if (!ry || rel_pulse) begin
                    last_nxt = LG_Y;
                    if (rx) begin
                        state_nxt = GRANT_X;
                        cnt_nxt   = RELOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (counter == '0) begin
                    cnt_nxt = RELOAD;
                    if (rx) begin
                        last_nxt  = LG_Y;
                        state_nxt = GRANT_X;
                    end
                end else begin
                    cnt_nxt = counter - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Arbiter state registers; reset leaves last_grant at Y so X wins the first contention.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= LG_Y;
            counter    <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_nxt;
            counter    <= cnt_nxt;
        end
    end

    // LEDs decode registered state and data only, so no switch reaches the LEDs combinationally.
    always_comb begin
        LEDR = 10'h000;
        case (state)
            GRANT_X: begin
                LEDR[3:0] = data_q[3:0] & DMASK;
                LEDR[8]   = 1'b1;
            end
            GRANT_Y: begin
                LEDR[3:0] = data_q[7:4] & DMASK;
                LEDR[9]   = 1'b1;
            end
            default: begin
                LEDR = 10'h000;
            end
        endcase
    end

endmodule
